// File: rtl/riscv_mem_pkg.sv
// Shared types and limits for the divided-clock memory controller.
package riscv_mem_pkg;

  localparam int MEM_MAX_WAIT   = 7;
  localparam int MEM_MAX_DIV    = 16;
  localparam int MEM_PHASE_BITS = $clog2(MEM_MAX_DIV);

  // One core-side access request as seen by a memory port.
  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic        read_enable;
    logic        write_enable;
    logic [31:0] write_data;
  } t_mem_access_req;

  // Response returned to the core: stall flag plus read data.
  typedef struct packed {
    logic        stall;
    logic [31:0] read_data;
  } t_mem_access_resp;

endpackage

// File: rtl/riscv_mem_port.sv
// One memory port: wait-state counter, SRAM drive and response muxing.
// Optional address range check enabled by RISCV_MEM_ADDR_CHECK_EN.
module riscv_mem_port
  import riscv_mem_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 14,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_access_phase,
  input  logic                     i_tick,
  input  t_mem_access_req          i_req,
  output t_mem_access_resp         o_resp,
  output logic                     o_sram_select,
  output logic                     o_sram_read_not_write,
  output logic [MEM_ADDR_BITS-1:0] o_sram_address,
  output logic [3:0]               o_sram_write_enable,
  output logic [31:0]              o_sram_write_data,
  input  logic [31:0]              i_sram_read_data,
  output logic                     o_addr_error
);

  localparam logic [2:0] WAIT_N = 3'(WAIT_STATES);

  logic [2:0] r_wcnt;
  logic       w_active;
  logic       w_count_done;
  logic       w_issue_slot;
  logic       w_out_of_range;
  logic       w_unused_addr_bits;

  assign w_active     = i_req.read_enable || i_req.write_enable;
  assign w_count_done = (r_wcnt == WAIT_N);
  // Slot in which the SRAM cycle would be issued if the address is legal.
  assign w_issue_slot = w_active && w_count_done && i_access_phase;

  // Wait counter advances only on core ticks; it clears when idle or after completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wcnt <= 3'd0;
    end else if (i_tick) begin
      r_wcnt <= (w_active && (r_wcnt < WAIT_N)) ? r_wcnt + 3'd1 : 3'd0;
    end
  end

`ifdef RISCV_MEM_ADDR_CHECK_EN
  logic r_addr_error;

  assign w_out_of_range = w_active && (|i_req.address[31:MEM_ADDR_BITS+2]);

  // Sticky error flag: set when an out-of-range access reaches its issue slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr_error <= 1'b0;
    end else if (w_issue_slot && w_out_of_range) begin
      r_addr_error <= 1'b1;
    end
  end

  assign o_addr_error = r_addr_error;
`else
  assign w_out_of_range = 1'b0;
  assign o_addr_error   = 1'b0;
`endif

  // Byte-offset bits never reach the SRAM; upper bits only matter to the range check.
  assign w_unused_addr_bits = ^{i_req.address[31:MEM_ADDR_BITS+2], i_req.address[1:0]};

  assign o_sram_select         = w_issue_slot && !w_out_of_range;
  assign o_sram_read_not_write = !i_req.write_enable;
  assign o_sram_address        = i_req.address[MEM_ADDR_BITS+1:2];
  assign o_sram_write_enable   = i_req.write_enable ? i_req.byte_enable : 4'h0;
  assign o_sram_write_data     = i_req.write_data;

  assign o_resp.stall     = w_active && !w_count_done;
  assign o_resp.read_data = w_out_of_range ? 32'h0 : i_sram_read_data;

endmodule

// File: rtl/riscv_mem_divider_ctrl.sv
// Memory-side controller for a RISC-V core clocked at clk/DIV_RATIO.
// Generates the core clock enable and drives separate imem/dmem SRAMs.
// Optional address range check enabled by RISCV_MEM_ADDR_CHECK_EN.
module riscv_mem_divider_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DIV_RATIO     = 2,
  parameter int MEM_ADDR_BITS = 14,
  parameter int IMEM_WAIT     = 0,
  parameter int DMEM_WAIT     = 0
) (
  input  logic                     clk,
  input  logic                     clk__enable,
  input  logic                     reset_n,
  output logic                     core_clk_enable,
  input  logic [31:0]              imem_req_address,
  input  logic [3:0]               imem_req_byte_enable,
  input  logic                     imem_req_read_enable,
  input  logic                     imem_req_write_enable,
  input  logic [31:0]              imem_req_write_data,
  output logic                     imem_resp_wait,
  output logic [31:0]              imem_resp_read_data,
  output logic                     imem_sram_select,
  output logic                     imem_sram_read_not_write,
  output logic [MEM_ADDR_BITS-1:0] imem_sram_address,
  output logic [3:0]               imem_sram_write_enable,
  output logic [31:0]              imem_sram_write_data,
  input  logic [31:0]              imem_sram_read_data,
  input  logic [31:0]              dmem_req_address,
  input  logic [3:0]               dmem_req_byte_enable,
  input  logic                     dmem_req_read_enable,
  input  logic                     dmem_req_write_enable,
  input  logic [31:0]              dmem_req_write_data,
  output logic                     dmem_resp_wait,
  output logic [31:0]              dmem_resp_read_data,
  output logic                     dmem_sram_select,
  output logic                     dmem_sram_read_not_write,
  output logic [MEM_ADDR_BITS-1:0] dmem_sram_address,
  output logic [3:0]               dmem_sram_write_enable,
  output logic [31:0]              dmem_sram_write_data,
  input  logic [31:0]              dmem_sram_read_data,
  output logic                     addr_error
);

  localparam logic [MEM_PHASE_BITS-1:0] ACCESS_PHASE = MEM_PHASE_BITS'(DIV_RATIO - 2);
  localparam logic [MEM_PHASE_BITS-1:0] TICK_PHASE   = MEM_PHASE_BITS'(DIV_RATIO - 1);

  logic [MEM_PHASE_BITS-1:0] r_phase;
  logic                      w_access_phase;
  logic                      w_tick;
  logic                      w_imem_addr_error;
  logic                      w_dmem_addr_error;
  t_mem_access_req           w_imem_req;
  t_mem_access_req           w_dmem_req;
  t_mem_access_resp          w_imem_resp;
  t_mem_access_resp          w_dmem_resp;

  // Phase counter: one lap per core tick, frozen while the global enable is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (clk__enable) begin
      r_phase <= (r_phase == TICK_PHASE) ? '0 : r_phase + MEM_PHASE_BITS'(1);
    end
  end

  // Strobes are held off during reset so an abandoned access never issues a select.
  assign w_access_phase  = clk__enable && reset_n && (r_phase == ACCESS_PHASE);
  assign w_tick          = clk__enable && reset_n && (r_phase == TICK_PHASE);
  assign core_clk_enable = w_tick;

  assign w_imem_req = '{address:      imem_req_address,
                        byte_enable:  imem_req_byte_enable,
                        read_enable:  imem_req_read_enable,
                        write_enable: imem_req_write_enable,
                        write_data:   imem_req_write_data};

  assign w_dmem_req = '{address:      dmem_req_address,
                        byte_enable:  dmem_req_byte_enable,
                        read_enable:  dmem_req_read_enable,
                        write_enable: dmem_req_write_enable,
                        write_data:   dmem_req_write_data};

  riscv_mem_port #(
    .MEM_ADDR_BITS (MEM_ADDR_BITS),
    .WAIT_STATES   (IMEM_WAIT)
  ) u_imem_port (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_access_phase        (w_access_phase),
    .i_tick                (w_tick),
    .i_req                 (w_imem_req),
    .o_resp                (w_imem_resp),
    .o_sram_select         (imem_sram_select),
    .o_sram_read_not_write (imem_sram_read_not_write),
    .o_sram_address        (imem_sram_address),
    .o_sram_write_enable   (imem_sram_write_enable),
    .o_sram_write_data     (imem_sram_write_data),
    .i_sram_read_data      (imem_sram_read_data),
    .o_addr_error          (w_imem_addr_error)
  );

  riscv_mem_port #(
    .MEM_ADDR_BITS (MEM_ADDR_BITS),
    .WAIT_STATES   (DMEM_WAIT)
  ) u_dmem_port (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_access_phase        (w_access_phase),
    .i_tick                (w_tick),
    .i_req                 (w_dmem_req),
    .o_resp                (w_dmem_resp),
    .o_sram_select         (dmem_sram_select),
    .o_sram_read_not_write (dmem_sram_read_not_write),
    .o_sram_address        (dmem_sram_address),
    .o_sram_write_enable   (dmem_sram_write_enable),
    .o_sram_write_data     (dmem_sram_write_data),
    .i_sram_read_data      (dmem_sram_read_data),
    .o_addr_error          (w_dmem_addr_error)
  );

  assign imem_resp_wait      = w_imem_resp.stall;
  assign imem_resp_read_data = w_imem_resp.read_data;
  assign dmem_resp_wait      = w_dmem_resp.stall;
  assign dmem_resp_read_data = w_dmem_resp.read_data;
  assign addr_error          = w_imem_addr_error || w_dmem_addr_error;

endmodule

// File: tb/tb_riscv_mem_divider_ctrl.sv
// Directed bench: DUT A (DIV 2, no waits) and DUT B (DIV 4, imem 1 / dmem 2 waits)
// share one request stimulus; each port has its own SRAM model.
// Port index: 0 = A imem, 1 = A dmem, 2 = B imem, 3 = B dmem.
module tb_riscv_mem_divider_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clk_en;
  logic        reset_n;
  logic [31:0] imem_addr, dmem_addr, imem_wd, dmem_wd;
  logic [3:0]  imem_be, dmem_be;
  logic        imem_re, imem_we, dmem_re, dmem_we;

  logic        ce    [2];
  logic        aerr  [2];
  logic        rwait [4];
  logic [31:0] rdata [4];
  logic        sel   [4];
  logic        rnw   [4];
  logic [13:0] saddr [4];
  logic [3:0]  swe   [4];
  logic [31:0] swd   [4];
  logic [31:0] srd   [4];

  logic        pre_en;
  int          pre_port;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int tests_run    = 0;
  int tests_failed = 0;

  // SRAM models: registered read one clk after select, byte-masked write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sram
    logic [31:0] mem [256];
    logic [31:0] rd;
    always @(posedge clk) begin
      if (pre_en && pre_port == gi) begin
        mem[pre_addr] <= pre_data;
      end else if (sel[gi]) begin
        if (rnw[gi]) begin
          rd <= mem[saddr[gi][7:0]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (swe[gi][b]) mem[saddr[gi][7:0]][8*b +: 8] <= swd[gi][8*b +: 8];
        end
      end
    end
    assign srd[gi] = rd;
  end

  riscv_mem_divider_ctrl #(
    .DIV_RATIO(2), .MEM_ADDR_BITS(14), .IMEM_WAIT(0), .DMEM_WAIT(0)
  ) u_dut_a (
    .clk(clk), .clk__enable(clk_en), .reset_n(reset_n), .core_clk_enable(ce[0]),
    .imem_req_address(imem_addr), .imem_req_byte_enable(imem_be),
    .imem_req_read_enable(imem_re), .imem_req_write_enable(imem_we),
    .imem_req_write_data(imem_wd), .imem_resp_wait(rwait[0]),
    .imem_resp_read_data(rdata[0]), .imem_sram_select(sel[0]),
    .imem_sram_read_not_write(rnw[0]), .imem_sram_address(saddr[0]),
    .imem_sram_write_enable(swe[0]), .imem_sram_write_data(swd[0]),
    .imem_sram_read_data(srd[0]),
    .dmem_req_address(dmem_addr), .dmem_req_byte_enable(dmem_be),
    .dmem_req_read_enable(dmem_re), .dmem_req_write_enable(dmem_we),
    .dmem_req_write_data(dmem_wd), .dmem_resp_wait(rwait[1]),
    .dmem_resp_read_data(rdata[1]), .dmem_sram_select(sel[1]),
    .dmem_sram_read_not_write(rnw[1]), .dmem_sram_address(saddr[1]),
    .dmem_sram_write_enable(swe[1]), .dmem_sram_write_data(swd[1]),
    .dmem_sram_read_data(srd[1]),
    .addr_error(aerr[0])
  );

  riscv_mem_divider_ctrl #(
    .DIV_RATIO(4), .MEM_ADDR_BITS(14), .IMEM_WAIT(1), .DMEM_WAIT(2)
  ) u_dut_b (
    .clk(clk), .clk__enable(clk_en), .reset_n(reset_n), .core_clk_enable(ce[1]),
    .imem_req_address(imem_addr), .imem_req_byte_enable(imem_be),
    .imem_req_read_enable(imem_re), .imem_req_write_enable(imem_we),
    .imem_req_write_data(imem_wd), .imem_resp_wait(rwait[2]),
    .imem_resp_read_data(rdata[2]), .imem_sram_select(sel[2]),
    .imem_sram_read_not_write(rnw[2]), .imem_sram_address(saddr[2]),
    .imem_sram_write_enable(swe[2]), .imem_sram_write_data(swd[2]),
    .imem_sram_read_data(srd[2]),
    .dmem_req_address(dmem_addr), .dmem_req_byte_enable(dmem_be),
    .dmem_req_read_enable(dmem_re), .dmem_req_write_enable(dmem_we),
    .dmem_req_write_data(dmem_wd), .dmem_resp_wait(rwait[3]),
    .dmem_resp_read_data(rdata[3]), .dmem_sram_select(sel[3]),
    .dmem_sram_read_not_write(rnw[3]), .dmem_sram_address(saddr[3]),
    .dmem_sram_write_enable(swe[3]), .dmem_sram_write_data(swd[3]),
    .dmem_sram_read_data(srd[3]),
    .addr_error(aerr[1])
  );

  task automatic idle();
    imem_addr = 32'h0; imem_be = 4'hF; imem_re = 1'b0; imem_we = 1'b0; imem_wd = 32'h0;
    dmem_addr = 32'h0; dmem_be = 4'hF; dmem_re = 1'b0; dmem_we = 1'b0; dmem_wd = 32'h0;
  endtask

  task automatic preload(input int p, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_port = p; pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Leaves the bench at the start of cycle 1 after release (phase 0 in both DUTs).
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; clk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    dmem_re = 1'b1; dmem_addr = 32'h20;
    @(negedge clk);
    reset_n = 1'b0; clk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (ce[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_ce dut%0d: got %b expected 0", d, ce[d]); end
      tests_run++;
      if (aerr[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_addr_error dut%0d: got %b expected 0", d, aerr[d]); end
    end
    for (int p = 0; p < 4; p++) begin
      tests_run++;
      if (sel[p] !== 1'b0) begin tests_failed++; $display("FAIL reset_select port%0d: got %b expected 0", p, sel[p]); end
    end
    tests_run++;
    if (rwait[3] !== 1'b1) begin tests_failed++; $display("FAIL reset_wait_n2: got %b expected 1", rwait[3]); end
    tests_run++;
    if (rwait[1] !== 1'b0) begin tests_failed++; $display("FAIL reset_wait_n0: got %b expected 0", rwait[1]); end
  endtask

  task automatic test_tick_pattern();
    idle();
    do_reset();
    for (int m = 1; m <= 8; m++) begin
      if (m > 1) @(negedge clk);
      #1;
      tests_run++;
      if (ce[0] !== (m % 2 == 0)) begin tests_failed++; $display("FAIL tick_div2 cycle%0d: got %b expected %b", m, ce[0], (m % 2 == 0)); end
      tests_run++;
      if (ce[1] !== (m % 4 == 0)) begin tests_failed++; $display("FAIL tick_div4 cycle%0d: got %b expected %b", m, ce[1], (m % 4 == 0)); end
    end
  endtask

  task automatic test_read_div2();
    idle();
    preload(0, 8'd4, 32'hDEAD_BEEF);
    imem_re = 1'b1; imem_addr = 32'h0000_0010;
    do_reset();
    #1;
    tests_run++;
    if (sel[0] !== 1'b1 || saddr[0] !== 14'd4 || rnw[0] !== 1'b1 || ce[0] !== 1'b0) begin
      tests_failed++; $display("FAIL read_select: sel %b addr %0d rnw %b ce %b expected 1 4 1 0", sel[0], saddr[0], rnw[0], ce[0]);
    end
    @(negedge clk); #1;
    tests_run++;
    if (ce[0] !== 1'b1 || rwait[0] !== 1'b0 || rdata[0] !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL read_complete: ce %b wait %b data %h expected 1 0 deadbeef", ce[0], rwait[0], rdata[0]);
    end
  endtask

  task automatic test_wait_states();
    idle();
    preload(3, 8'd8, 32'hCAFE_F00D);
    dmem_re = 1'b1; dmem_addr = 32'h0000_0020;
    do_reset();
    for (int m = 1; m <= 12; m++) begin
      if (m > 1) @(negedge clk);
      #1;
      tests_run++;
      if (sel[3] !== (m == 11)) begin tests_failed++; $display("FAIL wait_select cycle%0d: got %b expected %b", m, sel[3], (m == 11)); end
      if (m == 4 || m == 8) begin
        tests_run++;
        if (ce[1] !== 1'b1 || rwait[3] !== 1'b1) begin tests_failed++; $display("FAIL wait_stall cycle%0d: ce %b wait %b expected 1 1", m, ce[1], rwait[3]); end
      end
      if (m == 12) begin
        tests_run++;
        if (ce[1] !== 1'b1 || rwait[3] !== 1'b0 || rdata[3] !== 32'hCAFE_F00D) begin
          tests_failed++; $display("FAIL wait_complete: ce %b wait %b data %h expected 1 0 cafef00d", ce[1], rwait[3], rdata[3]);
        end
      end
    end
  endtask

  task automatic test_byte_write();
    idle();
    preload(1, 8'd2, 32'hAAAA_AAAA);
    dmem_we = 1'b1; dmem_be = 4'b0110; dmem_wd = 32'h1122_3344; dmem_addr = 32'h8;
    do_reset();
    #1;
    tests_run++;
    if (sel[1] !== 1'b1 || rnw[1] !== 1'b0 || swe[1] !== 4'b0110) begin
      tests_failed++; $display("FAIL bytewr_drive: sel %b rnw %b we %b expected 1 0 0110", sel[1], rnw[1], swe[1]);
    end
    @(negedge clk);
    @(negedge clk);
    dmem_we = 1'b0; dmem_re = 1'b1; dmem_be = 4'hF;
    #1;
    tests_run++;
    if (sel[1] !== 1'b1 || rnw[1] !== 1'b1 || swe[1] !== 4'h0) begin
      tests_failed++; $display("FAIL bytewr_readback_drive: sel %b rnw %b we %b expected 1 1 0000", sel[1], rnw[1], swe[1]);
    end
    @(negedge clk); #1;
    tests_run++;
    if (rdata[1] !== 32'hAA22_33AA) begin tests_failed++; $display("FAIL bytewr_data: got %h expected aa2233aa", rdata[1]); end
  endtask

  task automatic test_simultaneous();
    idle();
    imem_re = 1'b1; imem_addr = 32'h10;
    dmem_we = 1'b1; dmem_re = 1'b1; dmem_be = 4'hF; dmem_wd = 32'h1234_5678; dmem_addr = 32'hC;
    do_reset();
    #1;
    tests_run++;
    if (sel[0] !== 1'b1 || sel[1] !== 1'b1) begin tests_failed++; $display("FAIL simul_selects: imem %b dmem %b expected 1 1", sel[0], sel[1]); end
    tests_run++;
    if (rnw[1] !== 1'b0 || swe[1] !== 4'hF) begin tests_failed++; $display("FAIL simul_rw_is_write: rnw %b we %b expected 0 1111", rnw[1], swe[1]); end
    @(negedge clk); #1;
    tests_run++;
    if (ce[0] !== 1'b1 || rwait[0] !== 1'b0 || rwait[1] !== 1'b0) begin
      tests_failed++; $display("FAIL simul_complete: ce %b iwait %b dwait %b expected 1 0 0", ce[0], rwait[0], rwait[1]);
    end
    tests_run++;
    if (rdata[0] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL simul_imem_data: got %h expected deadbeef", rdata[0]); end
    tests_run++;
    if (g_sram[1].mem[3] !== 32'h1234_5678) begin tests_failed++; $display("FAIL simul_dmem_written: got %h expected 12345678", g_sram[1].mem[3]); end
  endtask

  task automatic test_clk_enable_freeze();
    idle();
    dmem_re = 1'b1; dmem_addr = 32'h20;
    do_reset();
    for (int m = 1; m <= 17; m++) begin
      if (m > 1) @(negedge clk);
      clk_en = !(m >= 6 && m <= 10);
      #1;
      tests_run++;
      if (sel[3] !== (m == 16)) begin tests_failed++; $display("FAIL freeze_select cycle%0d: got %b expected %b", m, sel[3], (m == 16)); end
      tests_run++;
      if (ce[1] !== (m == 4 || m == 13 || m == 17)) begin
        tests_failed++; $display("FAIL freeze_tick cycle%0d: got %b expected %b", m, ce[1], (m == 4 || m == 13 || m == 17));
      end
      if (m >= 6 && m <= 10) begin
        tests_run++;
        if (rwait[3] !== 1'b1) begin tests_failed++; $display("FAIL freeze_stall cycle%0d: got %b expected 1", m, rwait[3]); end
      end
      if (m == 17) begin
        tests_run++;
        if (rwait[3] !== 1'b0 || rdata[3] !== 32'hCAFE_F00D) begin
          tests_failed++; $display("FAIL freeze_complete: wait %b data %h expected 0 cafef00d", rwait[3], rdata[3]);
        end
      end
    end
  endtask

  task automatic test_addr_check();
    idle();
    preload(0, 8'd0, 32'h5A5A_5A5A);
    imem_re = 1'b1; imem_addr = 32'h0001_0000;
    do_reset();
    #1;
`ifdef RISCV_MEM_ADDR_CHECK_EN
    tests_run++;
    if (sel[0] !== 1'b0 || aerr[0] !== 1'b0) begin tests_failed++; $display("FAIL addrchk_no_select: sel %b err %b expected 0 0", sel[0], aerr[0]); end
    @(negedge clk); #1;
    tests_run++;
    if (ce[0] !== 1'b1 || rdata[0] !== 32'h0 || aerr[0] !== 1'b1) begin
      tests_failed++; $display("FAIL addrchk_complete: ce %b data %h err %b expected 1 0 1", ce[0], rdata[0], aerr[0]);
    end
    idle();
    repeat (20) @(negedge clk);
    #1;
    tests_run++;
    if (aerr[0] !== 1'b1) begin tests_failed++; $display("FAIL addrchk_sticky: got %b expected 1", aerr[0]); end
`else
    tests_run++;
    if (sel[0] !== 1'b1 || saddr[0] !== 14'd0) begin tests_failed++; $display("FAIL alias_select: sel %b addr %0d expected 1 0", sel[0], saddr[0]); end
    @(negedge clk); #1;
    tests_run++;
    if (rdata[0] !== 32'h5A5A_5A5A || aerr[0] !== 1'b0) begin
      tests_failed++; $display("FAIL alias_data: data %h err %b expected 5a5a5a5a 0", rdata[0], aerr[0]);
    end
    idle();
    repeat (20) @(negedge clk);
    #1;
    tests_run++;
    if (aerr[0] !== 1'b0) begin tests_failed++; $display("FAIL alias_no_error: got %b expected 0", aerr[0]); end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    clk_en  = 1'b1;
    pre_en  = 1'b0;
    pre_port = 0; pre_addr = 8'h0; pre_data = 32'h0;
    idle();
    test_reset();
    test_tick_pattern();
    test_read_div2();
    test_wait_states();
    test_byte_write();
    test_simultaneous();
    test_clk_enable_freeze();
    test_addr_check();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
